// File: rtl/prog_sequencer_pkg.sv
// Shared types and default constants for the program run sequencer.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CPU_RST,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TOUT
    } prog_seq_state_t;

    localparam logic [31:0] DIN_ADDR    = 32'h3E00;
    localparam logic [31:0] DOUT_ADDR   = 32'h3F00;
    localparam int          MAX_IO_SIZE = 256;
    localparam logic [31:0] HALT_PC     = 32'h14;

    // Result word count: negative return codes mean "no output".
    function automatic logic [31:0] calc_nwords(input logic [31:0] rc, input int unsigned max_words);
        if (rc[31])
            return 32'd0;
        else if (rc > 32'(max_words))
            return 32'(max_words);
        else
            return rc;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Host stream, processor memory port and status bundle of the run sequencer.
interface prog_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic             inValid;
    logic             inReady;
    logic [7:0]       inData;
    logic             inLast;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outWord;
    logic             outLast;
    logic             memEn;
    logic [31:0]      memAddr;
    logic [WIDTH-1:0] memData;
    logic [31:0]      memRdAddr;
    logic [7:0]       memRdData;
    logic             cpuReset;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] a0;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [WIDTH-1:0] retCode;

    modport master (
        input  start, inValid, inData, inLast, outReady, memRdData, pc, a0,
        output inReady, outValid, outWord, outLast, memEn, memAddr, memData,
               memRdAddr, cpuReset, busy, done, timeout, retCode
    );

    modport slave (
        output start, inValid, inData, inLast, outReady, memRdData, pc, a0,
        input  inReady, outValid, outWord, outLast, memEn, memAddr, memData,
               memRdAddr, cpuReset, busy, done, timeout, retCode
    );
endinterface

// File: rtl/prog_sequencer_io_word_packer.sv
// Collects four read-port bytes into a little-endian word and holds it until accepted.
module io_word_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cap_en,
    input  logic [1:0]       cap_lane,
    input  logic [7:0]       rd_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word
);
    logic             cap_q, cap_d;
    logic [1:0]       lane_q, lane_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;

    // The read port answers one cycle after the address, so the lane tag is delayed to match.
    always_comb begin
        cap_d   = cap_en;
        lane_d  = cap_lane;
        word_d  = word_q;
        valid_d = valid_q;
        if (valid_q && out_ready)
            valid_d = 1'b0;
        if (cap_q) begin
            word_d[{lane_q, 3'b000} +: 8] = rd_data;
            if (lane_q == 2'd3)
                valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cap_q   <= 1'b0;
            lane_q  <= 2'd0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_word  = word_q;
endmodule

// File: rtl/prog_sequencer.sv
// Job controller: loads input bytes, pulses processor reset, runs to halt or timeout, drains results.
module prog_sequencer #(
    parameter int          WIDTH          = 32,
    parameter logic [31:0] DIN_ADDR       = prog_seq_pkg::DIN_ADDR,
    parameter logic [31:0] DOUT_ADDR      = prog_seq_pkg::DOUT_ADDR,
    parameter int          MAX_IO_SIZE    = prog_seq_pkg::MAX_IO_SIZE,
    parameter logic [31:0] HALT_PC        = prog_seq_pkg::HALT_PC,
    parameter int          MAX_RUN_CYCLES = 100000,
    parameter int          RESET_CYCLES   = 2
) (
    input logic               clock,
    input logic               reset,
    prog_sequencer_if.master  bus
);
    import prog_seq_pkg::*;

    localparam int IDXW = $clog2(MAX_IO_SIZE) + 1;
    localparam int MAXW = MAX_IO_SIZE / 4;
    localparam int WDW  = $clog2(MAXW + 1);
    localparam int RCW  = $clog2(MAX_RUN_CYCLES + 1);
    localparam int RSW  = $clog2(RESET_CYCLES + 1);

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(MAX_IO_SIZE - 1);
    localparam logic [RCW-1:0]  RUN_LAST = RCW'(MAX_RUN_CYCLES - 1);
    localparam logic [RSW-1:0]  RST_LAST = RSW'(RESET_CYCLES - 1);

    prog_seq_state_t  state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [RSW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [RCW-1:0]   run_cnt_q, run_cnt_d;
    logic [WDW-1:0]   n_words_q, n_words_d;
    logic [WDW-1:0]   word_q, word_d;
    logic             rd_vld_q, rd_vld_d;
    logic [1:0]       rd_lane_q, rd_lane_d;
    logic             mem_en_q, mem_en_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_data_q, mem_data_d;
    logic [31:0]      mem_rd_addr_q, mem_rd_addr_d;
    logic [WIDTH-1:0] ret_code_q, ret_code_d;

    logic             in_acc, out_acc, pk_valid;
    logic [WIDTH-1:0] pk_word;
    logic [WDW-1:0]   word_nx, n_halt;

    assign in_acc  = bus.inValid && (state_q == ST_LOAD);
    assign out_acc = pk_valid && bus.outReady;
    assign word_nx = word_q + WDW'(1);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rst_cnt_d     = rst_cnt_q;
        run_cnt_d     = run_cnt_q;
        n_words_d     = n_words_q;
        word_d        = word_q;
        rd_vld_d      = 1'b0;
        rd_lane_d     = rd_lane_q;
        mem_en_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        mem_rd_addr_d = mem_rd_addr_q;
        ret_code_d    = ret_code_q;
        n_halt        = WDW'(calc_nwords(32'(bus.a0), MAXW));
        case (state_q)
            ST_IDLE, ST_DONE, ST_TOUT: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                if (in_acc) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = DIN_ADDR + 32'(idx_q);
                    mem_data_d = WIDTH'(bus.inData);
                    idx_d      = idx_q + IDXW'(1);
                    if (bus.inLast || idx_q == IDX_LAST) begin
                        state_d   = ST_CPU_RST;
                        rst_cnt_d = '0;
                    end
                end
            end
            ST_CPU_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RSW'(1);
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + RCW'(1);
                // Halt is checked first so it wins a tie with the timeout.
                if (32'(bus.pc) == HALT_PC) begin
                    ret_code_d = bus.a0;
                    n_words_d  = n_halt;
                    word_d     = '0;
                    state_d    = ST_DRAIN;
                    if (n_halt != '0) begin
                        mem_rd_addr_d = DOUT_ADDR;
                        rd_vld_d      = 1'b1;
                        rd_lane_d     = 2'd0;
                    end
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d = ST_TOUT;
                end
            end
            ST_DRAIN: begin
                if (n_words_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    if (rd_vld_q && rd_lane_q != 2'd3) begin
                        mem_rd_addr_d = mem_rd_addr_q + 32'd1;
                        rd_lane_d     = rd_lane_q + 2'd1;
                        rd_vld_d      = 1'b1;
                    end
                    if (out_acc) begin
                        if (word_nx == n_words_q) begin
                            state_d = ST_DONE;
                        end else begin
                            word_d        = word_nx;
                            mem_rd_addr_d = DOUT_ADDR + 32'({word_nx, 2'b00});
                            rd_vld_d      = 1'b1;
                            rd_lane_d     = 2'd0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            rst_cnt_q     <= '0;
            run_cnt_q     <= '0;
            n_words_q     <= '0;
            word_q        <= '0;
            rd_vld_q      <= 1'b0;
            rd_lane_q     <= 2'd0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_rd_addr_q <= '0;
            ret_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rst_cnt_q     <= rst_cnt_d;
            run_cnt_q     <= run_cnt_d;
            n_words_q     <= n_words_d;
            word_q        <= word_d;
            rd_vld_q      <= rd_vld_d;
            rd_lane_q     <= rd_lane_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            ret_code_q    <= ret_code_d;
        end
    end

    io_word_packer #(.WIDTH(WIDTH)) u_packer (
        .clock     (clock),
        .reset     (reset),
        .cap_en    (rd_vld_q),
        .cap_lane  (rd_lane_q),
        .rd_data   (bus.memRdData),
        .out_ready (bus.outReady),
        .out_valid (pk_valid),
        .out_word  (pk_word)
    );

    assign bus.inReady   = (state_q == ST_LOAD);
    assign bus.outValid  = pk_valid;
    assign bus.outWord   = pk_word;
    assign bus.outLast   = pk_valid && (word_nx == n_words_q);
    assign bus.memEn     = mem_en_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.memData   = mem_data_q;
    assign bus.memRdAddr = mem_rd_addr_q;
    assign bus.cpuReset  = (state_q != ST_RUN);
    assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_CPU_RST) ||
                           (state_q == ST_RUN)  || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.timeout   = (state_q == ST_TOUT);
    assign bus.retCode   = ret_code_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Job-level bench for prog_sequencer: table of jobs, random jobs and a reset-abort sequence.
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    localparam int MAXRUN = 300;
    localparam int RSTC   = 2;
    localparam int WIN    = 256;
    localparam int MAXW   = WIN / 4;

    typedef struct {
        int          nbytes;
        bit          last;
        bit          fixed;
        int          halt_after;   // negative: never halt
        logic [31:0] a0;
        bit          bp;
        int          exp_wr;
        int          exp_words;
    } job_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    prog_sequencer_if #(.WIDTH(32)) bus();

    prog_sequencer #(.WIDTH(32), .MAX_RUN_CYCLES(MAXRUN), .RESET_CYCLES(RSTC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  rdmem [WIN];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] words [$];
    bit          lasts [$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_words(input logic [31:0] a);
        if ($signed(a) < 0) return 0;
        if (a > 32'(MAXW))  return MAXW;
        return int'(a);
    endfunction

    // Byte memory seen by the read port, one cycle of latency.
    always @(posedge clock) begin
        if (bus.memRdAddr >= DOUT_ADDR && bus.memRdAddr < DOUT_ADDR + 32'(WIN))
            bus.memRdData <= rdmem[8'(bus.memRdAddr - DOUT_ADDR)];
        else
            bus.memRdData <= 8'h00;
    end

    always @(negedge clock) begin
        if (bus.memEn) begin
            wr_addr.push_back(bus.memAddr);
            wr_data.push_back(bus.memData);
        end
        if (prev_stall) begin
            chk("hold_valid", 32'(bus.outValid), 32'd1);
            chk("hold_word", bus.outWord, prev_word);
        end
        if (bus.outValid && bus.outReady) begin
            words.push_back(bus.outWord);
            lasts.push_back(bus.outLast);
        end
        prev_stall = bus.outValid && !bus.outReady;
        prev_word  = bus.outWord;
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        words.delete();
        lasts.delete();
    endtask

    task automatic run_job(input job_t v);
        logic [7:0] bytes [$];
        int acc, rc, n, cyc, hold, bad;
        bit bp_on;
        clear_mon();
        for (int i = 0; i < WIN; i++) rdmem[i] = 8'($urandom);
        for (int i = 0; i < v.nbytes; i++) bytes.push_back(v.fixed ? 8'(i + 1) : 8'($urandom));

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_load", 32'(bus.busy), 32'd1);
        chk("inready_load", 32'(bus.inReady), 32'd1);

        acc = 0;
        for (int i = 0; i < v.nbytes; i++) begin
            bus.inValid = 1'b1;
            bus.inData  = bytes[i];
            bus.inLast  = v.last && (i == v.nbytes - 1);
            if (!bus.inReady) break;
            tick();
            acc++;
        end
        bus.inValid = 1'b0;
        bus.inLast  = 1'b0;
        chk("accepted", 32'(acc), 32'(v.exp_wr));
        chk("inready_drop", 32'(bus.inReady), 32'd0);

        rc = 0;
        while (bus.cpuReset && rc < 10) begin
            rc++;
            tick();
        end
        chk("cpureset_cycles", 32'(rc), 32'(RSTC));
        chk("wr_count", 32'(wr_addr.size()), 32'(v.exp_wr));
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < v.exp_wr; i++)
            if (wr_addr[i] !== DIN_ADDR + 32'(i) || wr_data[i] !== 32'(bytes[i])) bad++;
        chk("wr_content", 32'(bad), 32'd0);
        if (wr_addr.size() > 0)
            chk("wr_last_addr", wr_addr[wr_addr.size() - 1], DIN_ADDR + 32'(v.exp_wr - 1));

        if (v.halt_after < 0) begin
            n = 0;
            while (!bus.cpuReset && n < MAXRUN + 20) begin
                n++;
                tick();
            end
            chk("run_cycles", 32'(n), 32'(MAXRUN));
            chk("tout_flag", 32'(bus.timeout), 32'd1);
            chk("tout_cpureset", 32'(bus.cpuReset), 32'd1);
            chk("tout_done", 32'(bus.done), 32'd0);
            chk("tout_busy", 32'(bus.busy), 32'd0);
            chk("tout_words", 32'(words.size()), 32'd0);
            return;
        end

        repeat (v.halt_after) tick();
        bus.pc = HALT_PC;
        bus.a0 = v.a0;
        tick();
        bus.pc = 32'h0;
        bus.a0 = 32'($urandom);
        chk("retcode_latch", bus.retCode, v.a0);
        if (v.exp_words == 0) begin
            tick();
            chk("zero_words_done", 32'(bus.done), 32'd1);
        end

        cyc = 0; hold = 0; bp_on = 1'b0;
        while (!bus.done && cyc < 4000) begin
            if (v.bp && !bp_on && words.size() == 1 && bus.outValid) bp_on = 1'b1;
            if (bp_on && hold < 20) begin
                bus.outReady = 1'b0;
                hold++;
            end else begin
                bus.outReady = ($urandom_range(0, 3) != 0);
            end
            tick();
            cyc++;
        end
        bus.outReady = 1'b0;
        chk("done_seen", 32'(bus.done), 32'd1);
        if (v.bp && v.exp_words > 1) chk("bp_applied", 32'(hold), 32'd20);
        chk("word_count", 32'(words.size()), 32'(v.exp_words));
        bad = 0;
        for (int w = 0; w < words.size() && w < v.exp_words; w++) begin
            if (words[w] !== {rdmem[4*w+3], rdmem[4*w+2], rdmem[4*w+1], rdmem[4*w]}) bad++;
            if (lasts[w] != (w == v.exp_words - 1)) bad++;
        end
        chk("word_content", 32'(bad), 32'd0);
        chk("done_retcode", bus.retCode, v.a0);
        chk("done_cpureset", 32'(bus.cpuReset), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_tout", 32'(bus.timeout), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_memEn"}, 32'(bus.memEn), 32'd0);
        chk({tag, "_memAddr"}, bus.memAddr, 32'd0);
        chk({tag, "_memData"}, bus.memData, 32'd0);
        chk({tag, "_memRdAddr"}, bus.memRdAddr, 32'd0);
        chk({tag, "_cpuReset"}, 32'(bus.cpuReset), 32'd1);
        chk({tag, "_inReady"}, 32'(bus.inReady), 32'd0);
        chk({tag, "_outValid"}, 32'(bus.outValid), 32'd0);
        chk({tag, "_outLast"}, 32'(bus.outLast), 32'd0);
        chk({tag, "_outWord"}, bus.outWord, 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
        chk({tag, "_retCode"}, bus.retCode, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t jobs [7];
        job_t r;
        int   rc, sel;
        //         nbytes last fixed halt        a0           bp exp_wr words
        jobs[0] = '{8,   1, 1, 10,         32'd2,        0, 8,   2};
        jobs[1] = '{300, 0, 0, 3,          32'd1,        0, 256, 1};
        jobs[2] = '{5,   1, 0, -1,         32'd0,        0, 5,   0};
        jobs[3] = '{3,   1, 0, 2,          32'd100,      0, 3,   64};
        jobs[4] = '{1,   1, 0, 0,          32'hFFFFFFFF, 0, 1,   0};
        jobs[5] = '{4,   1, 0, 4,          32'd6,        1, 4,   6};
        jobs[6] = '{2,   1, 0, MAXRUN - 1, 32'd3,        0, 2,   3};

        bus.start = 1'b0; bus.inValid = 1'b0; bus.inData = 8'h0; bus.inLast = 1'b0;
        bus.outReady = 1'b0; bus.pc = 32'h0; bus.a0 = 32'h0;
        reset = 1'b0;
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        for (int j = 0; j < 7; j++) run_job(jobs[j]);

        // Abort during RUN, then a fresh job must still complete.
        clear_mon();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.inValid = 1'b1;
            bus.inData  = 8'(8'hA0 + i);
            bus.inLast  = (i == 3);
            tick();
        end
        bus.inValid = 1'b0;
        bus.inLast  = 1'b0;
        rc = 0;
        while (bus.cpuReset && rc < 10) begin
            rc++;
            tick();
        end
        repeat (5) tick();
        chk("abort_in_run", 32'(bus.cpuReset), 32'd0);
        reset = 1'b0;
        tick();
        check_reset_values("abort");
        reset = 1'b1;
        tick();
        run_job('{6, 1, 0, 7, 32'd3, 0, 6, 3});

        for (int k = 0; k < 6; k++) begin
            r.nbytes = $urandom_range(1, 300);
            r.last   = (r.nbytes < WIN) ? 1'b1 : 1'($urandom_range(0, 1));
            r.fixed  = 1'b0;
            r.halt_after = $urandom_range(0, 20);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       r.a0 = 32'($urandom_range(0, 10));
                1:       r.a0 = 32'($urandom_range(60, 80));
                2:       r.a0 = 32'h80000000 | 32'($urandom);
                default: r.a0 = 32'($urandom_range(1, 5));
            endcase
            r.bp        = 1'($urandom_range(0, 1));
            r.exp_wr    = (r.nbytes < WIN) ? r.nbytes : WIN;
            r.exp_words = model_words(r.a0);
            run_job(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
